// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 write decoder with a 2x16 DDRAM mirror, cursor/entry/display tracking.
// Define LCD_MON_BUSY_EN to model controller busy time and flag writes that arrive while busy.
module lcd_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CYC    = 2000,
  parameter int CLR_CYC     = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic       RW,
  input  logic       RS,
  input  logic [7:0] lcd,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       char_valid,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [4:0] cursor,
  output logic       disp_on,
  output logic       busy,
  input  logic       clr_ovr,
  output logic       overrun
);
  logic [SYNC_STAGES:0]      e_q;
  logic [SYNC_STAGES:0][9:0] bus_q;
  logic [7:0] mem [32];

  logic [7:0] rd_data_q, cmd_code_q, cmd_code_d;
  logic       char_valid_q, char_valid_d, cmd_valid_q, cmd_valid_d;
  logic [4:0] cursor_q, cursor_d, fidx_q, fidx_d;
  logic       disp_on_q, disp_on_d, id_q, id_d, fill_q, fill_d, ovr_q, ovr_d;
  logic       e_fall, rw_s, rs_s, wr_req, accept, busy_w, load_busy, load_clr, we;
  logic [7:0] byte_s, wdata;
  logic [4:0] waddr;

  // RW/RS/lcd run one stage deeper than E so the captured byte predates the E fall.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      e_q   <= '0;
      bus_q <= '0;
    end else begin
      e_q   <= {e_q[SYNC_STAGES-1:0], E};
      bus_q <= {bus_q[SYNC_STAGES-1:0], {RW, RS, lcd}};
    end

  always_comb begin
    e_fall       = e_q[SYNC_STAGES] & ~e_q[SYNC_STAGES-1];
    {rw_s, rs_s, byte_s} = bus_q[SYNC_STAGES];
    wr_req       = e_fall & ~rw_s;
    accept       = wr_req & ~busy_w;
    load_busy    = accept;
    load_clr     = 1'b0;
    cursor_d     = cursor_q;
    cmd_code_d   = cmd_code_q;
    disp_on_d    = disp_on_q;
    id_d         = id_q;
    char_valid_d = 1'b0;
    cmd_valid_d  = 1'b0;
    fill_d       = fill_q;
    fidx_d       = fidx_q;
    we           = 1'b0;
    waddr        = fidx_q;
    wdata        = 8'h20;
    if (fill_q) begin
      we     = 1'b1;
      fidx_d = fidx_q + 5'd1;
      if (fidx_q == 5'd31) fill_d = 1'b0;
    end
    if (accept && rs_s) begin
      we           = 1'b1;
      waddr        = cursor_q;
      wdata        = byte_s;
      cursor_d     = id_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
      char_valid_d = 1'b1;
    end else if (accept) begin
      cmd_valid_d = 1'b1;
      cmd_code_d  = byte_s;
      casez (byte_s)
        8'b1???????: if (byte_s[5:4] == 2'b00) cursor_d = {byte_s[6], byte_s[3:0]};
        8'b01??????, 8'b001?????: ;
        8'b0001????: if (!byte_s[3]) cursor_d = byte_s[2] ? cursor_q + 5'd1 : cursor_q - 5'd1;
        8'b00001???: disp_on_d = byte_s[2];
        8'b000001??: id_d = byte_s[1];
        8'b0000001?: cursor_d = '0;
        8'b00000001: begin
          cursor_d = '0;
          id_d     = 1'b1;
          fill_d   = 1'b1;
          fidx_d   = '0;
          load_clr = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LCD_MON_BUSY_EN
  localparam int CMAX = (BUSY_CYC > CLR_CYC) ? BUSY_CYC : CLR_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    if (load_clr)       cnt_d = CW'(CLR_CYC);
    else if (load_busy) cnt_d = CW'(BUSY_CYC);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign busy_w = fill_q | (cnt_q != '0);

  // A drop in the same cycle as clr_ovr keeps the flag set.
  always_comb begin
    ovr_d = ovr_q;
    if (clr_ovr)          ovr_d = 1'b0;
    if (wr_req && busy_w) ovr_d = 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = clr_ovr ^ load_busy ^ (BUSY_CYC > CLR_CYC);
  assign busy_w     = fill_q;
  assign ovr_d      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_data_q    <= 8'h00;
      char_valid_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= 8'h00;
      cursor_q     <= '0;
      disp_on_q    <= 1'b0;
      id_q         <= 1'b1;
      fill_q       <= 1'b1;
      fidx_q       <= '0;
      ovr_q        <= 1'b0;
    end else begin
      rd_data_q    <= mem[rd_addr];
      char_valid_q <= char_valid_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      cursor_q     <= cursor_d;
      disp_on_q    <= disp_on_d;
      id_q         <= id_d;
      fill_q       <= fill_d;
      fidx_q       <= fidx_d;
      ovr_q        <= ovr_d;
    end

  // Mirror contents survive reset; the post-reset fill rewrites them.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rd_data    = rd_data_q;
  assign char_valid = char_valid_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign cursor     = cursor_q;
  assign disp_on    = disp_on_q;
  assign busy       = busy_w;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: transaction-level model checked every cycle plus literal expectations.
module tb_lcd_bus_monitor;
  localparam int S   = 2;
  localparam int BC  = 200;
  localparam int CC  = 64;
  localparam int GAP = 300;

  logic       clk = 1'b0, rst = 1'b1, E = 1'b0, RW = 1'b1, RS = 1'b0, clr_ovr = 1'b0;
  logic [7:0] lcd = 8'h00;
  logic [4:0] rd_addr = 5'd0, rd_tgt = 5'd0;
  logic       sweep_en = 1'b1;
  logic [7:0] rd_data, cmd_code;
  logic [4:0] cursor;
  logic       char_valid, cmd_valid, disp_on, busy, overrun;

  int checks = 0, failures = 0, ncmd = 0;

  always #5 clk = ~clk;

  lcd_bus_monitor #(.SYNC_STAGES(S), .BUSY_CYC(BC), .CLR_CYC(CC)) dut (
    .clk(clk), .rst(rst), .E(E), .RW(RW), .RS(RS), .lcd(lcd), .rd_addr(rd_addr),
    .rd_data(rd_data), .char_valid(char_valid), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cursor(cursor), .disp_on(disp_on), .busy(busy), .clr_ovr(clr_ovr), .overrun(overrun)
  );

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: every write lands S edges after the raw E fall.
  typedef struct { int due; bit rw; bit rs; int b; } txn_t;
  txn_t q[$];
  int   m_mem[32];
  int   m_cur, m_cmd, m_rd, fill_base = -1000, busy_end = 0, cyc = 0, pb = 0;
  bit   m_id, m_disp, m_ovr, m_chv, m_cmv, m_ok = 0, pe = 0, prw = 1, prs = 0;

  function automatic bit busy_at(int n);
    bit b;
    b = (n < fill_base + 32);
`ifdef LCD_MON_BUSY_EN
    b = b || (n < busy_end);
`endif
    return b;
  endfunction

  function automatic void apply(txn_t t, bit bz);
    if (t.rw) return;
    if (bz) begin
`ifdef LCD_MON_BUSY_EN
      m_ovr = 1'b1;
`endif
      return;
    end
    busy_end = cyc + BC;
    if (t.rs) begin
      m_mem[m_cur] = t.b;
      m_cur = m_id ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
      m_chv = 1'b1;
    end else begin
      m_cmv = 1'b1;
      m_cmd = t.b;
      if (t.b >= 'h80) begin
        if (((t.b >> 4) & 3) == 0) m_cur = ((t.b >> 6) & 1) * 16 + (t.b & 15);
      end else if (t.b >= 'h20) begin
      end else if (t.b >= 'h10) begin
        if (((t.b >> 3) & 1) == 0) m_cur = (((t.b >> 2) & 1) != 0) ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
      end else if (t.b >= 'h08) m_disp = ((t.b >> 2) & 1) != 0;
      else if (t.b >= 'h04) m_id = ((t.b >> 1) & 1) != 0;
      else if (t.b >= 'h02) m_cur = 0;
      else if (t.b == 'h01) begin
        m_cur = 0;
        m_id = 1'b1;
        fill_base = cyc;
        busy_end = cyc + CC;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit bz;
    cyc++;
    if (rst) begin
      m_ok = 1'b1; m_cur = 0; m_cmd = 0; m_rd = 0; m_id = 1'b1; m_disp = 1'b0;
      m_ovr = 1'b0; m_chv = 1'b0; m_cmv = 1'b0;
      fill_base = cyc; busy_end = 0; pe = 1'b0;
      q.delete();
    end else begin
      bz = busy_at(cyc - 1);
      m_rd = m_mem[rd_addr];
      m_chv = 1'b0;
      m_cmv = 1'b0;
      if (cyc > fill_base && cyc <= fill_base + 32) m_mem[cyc - fill_base - 1] = 'h20;
      if (clr_ovr) m_ovr = 1'b0;
      while (q.size() > 0 && q[0].due == cyc) apply(q.pop_front(), bz);
      if (pe && !E) q.push_back('{cyc + S, prw, prs, pb});
      pe = E;
    end
    prw = RW; prs = RS; pb = int'(lcd);
  end

  always @(negedge clk) begin
    if (cmd_valid) ncmd++;
    if (m_ok && !rst) begin
      if (m_rd >= 0) chk("rd_data", int'(rd_data), m_rd);
      chk("char_valid", int'(char_valid), int'(m_chv));
      chk("cmd_valid",  int'(cmd_valid),  int'(m_cmv));
      chk("cmd_code",   int'(cmd_code),   m_cmd);
      chk("cursor",     int'(cursor),     m_cur);
      chk("disp_on",    int'(disp_on),    int'(m_disp));
      chk("busy",       int'(busy),       int'(busy_at(cyc)));
      chk("overrun",    int'(overrun),    int'(m_ovr));
    end
  end

  always @(posedge clk) begin
    #2;
    if (sweep_en) rd_addr = rd_addr + 5'd1;
    else          rd_addr = rd_tgt;
  end

  task automatic wr(bit rs, bit rw, logic [7:0] b, int gap);
    @(posedge clk); #2;
    RS = rs; RW = rw; lcd = b; E = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    E = 1'b0; lcd = ~b; RW = 1'b1; RS = ~rs;
    repeat (gap) @(posedge clk);
  endtask

  task automatic rd(logic [4:0] a, logic [7:0] exp, string nm);
    sweep_en = 1'b0; rd_tgt = a;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(nm, int'(rd_data), int'(exp));
    sweep_en = 1'b1;
  endtask

  task automatic chk_rst(string tag);
    chk({tag, "_rd_data"},    int'(rd_data),    0);
    chk({tag, "_char_valid"}, int'(char_valid), 0);
    chk({tag, "_cmd_valid"},  int'(cmd_valid),  0);
    chk({tag, "_cmd_code"},   int'(cmd_code),   0);
    chk({tag, "_cursor"},     int'(cursor),     0);
    chk({tag, "_disp_on"},    int'(disp_on),    0);
    chk({tag, "_overrun"},    int'(overrun),    0);
    chk({tag, "_busy"},       int'(busy),       1);
  endtask

  task automatic fill_window(string tag);
    @(posedge clk); #2 rst = 1'b0;
    repeat (31) @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy_31"}, int'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy_32"}, int'(busy), 0);
    chk({tag, "_cursor"}, int'(cursor), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = -1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_rst("reset");
    fill_window("init");
    rd(5'd0, 8'h20, "rd_fill0");
    rd(5'd31, 8'h20, "rd_fill31");

    ncmd = 0;
    wr(0, 0, 8'h38, GAP); wr(0, 0, 8'h0C, GAP); wr(0, 0, 8'h06, GAP); wr(0, 0, 8'h01, GAP);
    wr(1, 0, 8'h48, GAP); wr(1, 0, 8'h49, GAP);
    @(negedge clk);
    chk("cmd_count", ncmd, 4);
    chk("disp_on_0C", int'(disp_on), 1);
    chk("cursor_HI", int'(cursor), 2);
    chk("cmd_code_clr", int'(cmd_code), 'h01);
    chk("model_mem0_H", m_mem[0], 'h48);
    rd(5'd0, 8'h48, "rd_H");
    rd(5'd1, 8'h49, "rd_I");

    wr(0, 0, 8'hC5, GAP); wr(1, 0, 8'h41, GAP);
    @(negedge clk);
    chk("cursor_C5", int'(cursor), 22);
    chk("model_mem21", m_mem[21], 'h41);
    rd(5'd21, 8'h41, "rd_21");
    wr(0, 0, 8'hA0, GAP);
    @(negedge clk);
    chk("cursor_A0", int'(cursor), 22);
    chk("cmd_code_A0", int'(cmd_code), 'hA0);

    wr(0, 0, 8'h04, GAP); wr(0, 0, 8'h80, GAP); wr(1, 0, 8'h5A, GAP);
    @(negedge clk);
    chk("cursor_wrap", int'(cursor), 31);
    chk("model_cur_wrap", m_cur, 31);
    rd(5'd0, 8'h5A, "rd_5A");

    ncmd = 0;
    wr(0, 1, 8'h01, GAP);
    @(negedge clk);
    chk("rw_read_ignored", ncmd, 0);
    chk("cmd_code_after_read", int'(cmd_code), 'h80);
    wr(0, 0, 8'h14, GAP); @(negedge clk); chk("shift_right_wrap", int'(cursor), 0);
    wr(0, 0, 8'h10, GAP); @(negedge clk); chk("shift_left_wrap", int'(cursor), 31);
    wr(0, 0, 8'h18, GAP); @(negedge clk); chk("display_shift_ign", int'(cursor), 31);
    wr(0, 0, 8'h02, GAP); @(negedge clk); chk("home", int'(cursor), 0);
    wr(0, 0, 8'h08, GAP); @(negedge clk); chk("disp_off", int'(disp_on), 0);

    wr(0, 0, 8'h06, GAP);
    wr(1, 0, 8'h31, 100);
    wr(1, 0, 8'h32, GAP);
    @(negedge clk);
    rd(5'd0, 8'h31, "rd_first");
`ifdef LCD_MON_BUSY_EN
    chk("overrun_set", int'(overrun), 1);
    chk("cursor_drop", int'(cursor), 1);
    rd(5'd1, 8'h49, "rd_dropped");
`else
    chk("overrun_tied", int'(overrun), 0);
    chk("cursor_nodrop", int'(cursor), 2);
    rd(5'd1, 8'h32, "rd_second");
`endif
    @(posedge clk); #2 clr_ovr = 1'b1;
    @(posedge clk); #2 clr_ovr = 1'b0;
    @(negedge clk);
    chk("overrun_clr", int'(overrun), 0);

    wr(0, 0, 8'h01, 2);
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("midfill_busy", int'(busy), 1);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk_rst("midfill_rst");
    fill_window("refill");
    rd(5'd21, 8'h20, "rd_refill21");
    rd(5'd1, 8'h20, "rd_refill1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_bus_monitor.md
# lcd_bus_monitor

Passive responder on the HD44780-style LCD bus (E, RW, RS, 8-bit data) driven by our LCD controller. It decodes every write transaction, maintains a 2x16-character DDRAM mirror, tracks cursor, entry mode and display-on state, and models controller busy time so that timing violations by the driver are flagged. The block sits beside the LCD pins as a bench/ILA checker and as a source for mirroring the display to other outputs.

## Interface
- SYNC_STAGES, 2, synchronizer depth for E/RW/RS/lcd (>=2)
- BUSY_CYC, 2000, busy time after a normal write in clk cycles (40 us at 50 MHz, >=1)
- CLR_CYC, 82000, busy time after clear (1.64 ms at 50 MHz, >=32)
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- E, RW, RS  in  1 each  LCD bus strobes as driven by the controller
- lcd  in  8  LCD data bus
- rd_addr  in  5  mirror read index (0-15 line 1, 16-31 line 2)
- rd_data  out  8  DDRAM[rd_addr], registered
- char_valid  out  1  one-cycle pulse per accepted data write
- cmd_valid  out  1  one-cycle pulse per accepted command
- cmd_code  out  8  last accepted command byte
- cursor  out  5  current DDRAM index
- disp_on  out  1  display-on bit from last display-control command
- busy  out  1  modelled controller busy
- clr_ovr  in  1  clears overrun
- overrun  out  1  sticky: transaction arrived while busy

## Operation
- E, RW, RS, lcd pass through SYNC_STAGES flops; RW/RS/lcd carry one extra stage so captured values are those sampled while E was still high.
- Transaction = synchronized E falling edge. RW=1: ignored (no pulse, no busy). RW=0 while busy: transaction dropped, overrun<=1.
- RS=1 data write: DDRAM[cursor]<=byte; cursor +1 (I/D=1) or -1 (I/D=0), wrapping mod 32 (31->0, 0->31); char_valid pulse.
- RS=0 command, decoded by highest set bit; cmd_code<=byte, cmd_valid pulse for all:
  - 0x01 clear: sequential fill of all 32 bytes with 0x20, one per cycle; cursor<=0; I/D<=1.
  - 0x02-0x03 home: cursor<=0.
  - 0x04-0x07 entry mode: I/D<=bit1; bit0 (shift) ignored.
  - 0x08-0x0F: disp_on<=bit2; cursor/blink ignored.
  - 0x10-0x1F: S/C=0 moves cursor by R/L (bit2=1 +1, else -1), wrapping; S/C=1 ignored.
  - 0x20-0x7F function set / CGRAM address: no state effect.
  - 0x80-0xFF DDRAM address: bits[5:4]=00 -> cursor<={bit6,bits[3:0]}; otherwise cursor unchanged.
- Busy: accepted write loads counter with BUSY_CYC (clear: CLR_CYC); busy=1 while counter nonzero. Clear fill occupies the first 32 cycles of its busy window.
- rd_data reflects fill progress (mixed old/0x20 mid-fill).
- clr_ovr clears overrun; overrun set in the same cycle wins.

## Timing
- Reset values: rd_data 0x00, char_valid 0, cmd_valid 0, cmd_code 0x00, cursor 0, disp_on 0, overrun 0, busy 1, I/D 1.
- DDRAM contents are not reset; release of rst starts a 32-cycle fill with 0x20, busy drops at cycle 32; transactions during it are dropped with overrun.
- Reset asserted mid-fill or mid-busy: all state returns to reset values; fill restarts from index 0 on release.
- t0 = first clk edge sampling raw E low after high. Pulses, cursor/DDRAM/state updates and busy rise all take effect at edge t0+SYNC_STAGES; pulses last one cycle.
- Bus requirements: E high >= 2 clk cycles; RS/RW/lcd stable >= 1 cycle before E falls; hold 0 cycles.
- rd_data latency: 1 cycle from rd_addr; a write to the addressed byte is visible the cycle after it lands.

## Configuration
- LCD_MON_BUSY_EN defined: busy modelling with BUSY_CYC/CLR_CYC and overrun as above.
- Undefined: busy asserted only during 32-cycle fills (reset and clear); transactions during a fill are dropped; overrun tied 0; BUSY_CYC/CLR_CYC unused.

## Test plan
- Reset release, wait 32 cycles -> busy falls, all 32 rd_data reads = 0x20, cursor 0.
- Commands 0x38, 0x0C, 0x06, 0x01 spaced > CLR_CYC, then data 'H','I' -> cmd_valid x4, disp_on 1, DDRAM[0]=0x48, DDRAM[1]=0x49, cursor 2.
- Command 0xC5 then data 0x41 -> DDRAM[21]=0x41, cursor 22; command 0xA0 -> cursor unchanged.
- Entry 0x04, cursor 0, data 0x5A -> DDRAM[0]=0x5A, cursor 31 (wrap).
- Second write 100 cycles after first (BUSY_CYC=2000) -> dropped, overrun 1, DDRAM unchanged; clr_ovr pulse -> overrun 0.
- Reset asserted 10 cycles into a clear fill -> outputs at reset values; after release full refill, busy low after 32 cycles.
